reg_file_wb_arbiter: RTL
========================

Name: reg_file_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: the ALU/immediate path (port A) and the data-memory load-return path (port L).
- Uses valid/ready handshakes on both requesters and round-robin arbitration on conflict.
- Formats write data: ALU result, LUI immediate, load word, or extracted load byte.
- Registers the selected write onto the register-file port and counts conflict cycles for performance monitoring.

Parameters:
DATA_W, 32, register/write-data width
ADDR_W, 5, register index width
CNT_W, 16, width of the saturating conflict counter

Ports:
clock  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
w_a_valid  in  1  ALU-path writeback request
w_a_ready  out  1  ALU-path request accepted this cycle
w_a_imm_op  in  1  1: write {w_a_imm16, 16'h0} (LUI); 0: write w_a_result
w_a_waddr  in  ADDR_W  destination register
w_a_result  in  DATA_W  ALU result
w_a_imm16  in  16  immediate for LUI
w_l_valid  in  1  load-return request
w_l_ready  out  1  load-return accepted this cycle
w_l_byte_op  in  1  1: byte load; 0: word load
w_l_signed  in  1  byte load sign-extends when 1, zero-extends when 0
w_l_boff  in  2  byte offset within word (0 = bits 7:0)
w_l_waddr  in  ADDR_W  destination register
w_l_rdata  in  DATA_W  raw memory word
w_flush  in  1  squash: ALU port not accepted while high
w_rf_we  out  1  register-file write enable
w_rf_waddr  out  ADDR_W  register-file write address
w_rf_wdata  out  DATA_W  register-file write data
w_wdata_sel  out  2  source of the current write: 00 load word, 01 load byte, 10 LUI, 11 ALU
w_conflict_cnt  out  CNT_W  saturating count of cycles both requesters were eligible

Behaviour:
- Reset (reset_n low, asynchronous): w_rf_we=0, w_rf_waddr=0, w_rf_wdata=0, w_wdata_sel=00, w_conflict_cnt=0, priority pointer = L.
- Eligibility: A is eligible when w_a_valid && !w_flush. L is eligible when w_l_valid.
- Readies are combinational from eligibility and the pointer; the register-file port never back-pressures.
- Arbitration:
  - Only A eligible: grant A.
  - Only L eligible: grant L.
  - Both eligible: grant the requester named by the pointer; the other sees ready=0 and must hold its request stable.
  - The pointer updates only on a conflict cycle and flips to the loser, so a requester never loses two consecutive conflicts.
- At most one grant per cycle. w_a_ready and w_l_ready are never both 1.
- Latency: a grant in cycle N produces w_rf_we=1 with the address, data and sel in cycle N+1, held exactly one cycle. With no grant, w_rf_we=0 in N+1; address, data and sel hold their previous values.
- Write to register 0: the handshake completes normally, but w_rf_we=0 in N+1. w_wdata_sel and data still update.
- Data formatting, registered in the grant cycle:
  - ALU: w_a_result, sel=11.
  - LUI: {w_a_imm16, 16'h0000}, sel=10.
  - Load word: w_l_rdata unchanged, sel=00.
  - Load byte: select byte w_l_rdata[8*boff+7 : 8*boff], sign- or zero-extend to DATA_W, sel=01.
- Flush: w_flush high forces w_a_ready=0, and A does not count as a conflict. L proceeds unaffected. A request granted in the cycle before flush still writes in the following cycle.
- Conflict counter: increments by 1 in every cycle where both are eligible. It saturates at all-ones and does not wrap.
- Reset mid-operation: a pending output write is discarded (w_rf_we drops to 0 immediately). No request is remembered.
- Requesters must keep valid and payload stable until ready. Behaviour is undefined if the payload changes while valid is high and ready is low.

Test Plan:
- ALU only: w_a_valid=1, waddr=5, result=32'hDEADBEEF -> ready=1 same cycle; next cycle rf_we=1, waddr=5, wdata=DEADBEEF, sel=11.
- Load byte signed: w_l_valid=1, byte_op=1, signed=1, boff=2, rdata=32'h12_80_34_56, waddr=9 -> next cycle wdata=32'hFFFFFF80, sel=01. Repeat with signed=0 -> 32'h00000080.
- Conflict fairness: both valid for 4 cycles, each re-presenting after grant, starting from the reset pointer -> grants L, A, L, A; w_conflict_cnt=4; no requester loses twice in a row.
- LUI and r0: A imm_op=1, imm16=16'h1234, waddr=3 -> wdata=32'h12340000, sel=10, we=1. Then waddr=0 -> handshake completes, rf_we=0.
- Flush: both valid with w_flush=1 for 2 cycles -> only L granted, A ready=0, conflict_cnt unchanged. Flush drops -> A granted next cycle.
- Async reset mid-write: assert reset_n=0 in the cycle rf_we=1 -> rf_we=0 without waiting for a clock edge, counter=0. After release, an L request is granted first on conflict.

Source files
------------

// File: rtl/reg_file_wb_arbiter_if.sv
// Writeback bundle between the two writeback requesters (ALU path A,
// load-return path L) and the register-file write port.
//   slave  : seen by the arbiter (requests in, readies and RF write out)
//   master : seen by whatever drives the requests and watches the RF port
interface reg_file_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  // ALU / immediate requester
  logic              w_a_valid;
  logic              w_a_ready;
  logic              w_a_imm_op;
  logic [ADDR_W-1:0] w_a_waddr;
  logic [DATA_W-1:0] w_a_result;
  logic [15:0]       w_a_imm16;
  // Load-return requester
  logic              w_l_valid;
  logic              w_l_ready;
  logic              w_l_byte_op;
  logic              w_l_signed;
  logic [1:0]        w_l_boff;
  logic [ADDR_W-1:0] w_l_waddr;
  logic [DATA_W-1:0] w_l_rdata;
  // Squash of the ALU path
  logic              w_flush;
  // Register-file write port and monitoring
  logic              w_rf_we;
  logic [ADDR_W-1:0] w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;
  logic [1:0]        w_wdata_sel;
  logic [CNT_W-1:0]  w_conflict_cnt;

  modport slave (
    input  w_a_valid, w_a_imm_op, w_a_waddr, w_a_result, w_a_imm16,
    input  w_l_valid, w_l_byte_op, w_l_signed, w_l_boff, w_l_waddr, w_l_rdata,
    input  w_flush,
    output w_a_ready, w_l_ready,
    output w_rf_we, w_rf_waddr, w_rf_wdata, w_wdata_sel, w_conflict_cnt
  );

  modport master (
    output w_a_valid, w_a_imm_op, w_a_waddr, w_a_result, w_a_imm16,
    output w_l_valid, w_l_byte_op, w_l_signed, w_l_boff, w_l_waddr, w_l_rdata,
    output w_flush,
    input  w_a_ready, w_l_ready,
    input  w_rf_we, w_rf_waddr, w_rf_wdata, w_wdata_sel, w_conflict_cnt
  );
endinterface

// File: rtl/reg_file_wb_arbiter.sv
// Register-file writeback arbiter.
// Shares the single register-file write port between the ALU/immediate path
// (A) and the load-return path (L). Round-robin on conflict, write data is
// formatted (ALU, LUI, load word, extended load byte) and registered so a
// grant in cycle N writes in cycle N+1. Counts conflict cycles, saturating.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : writeback bundle (slave modport) - requests, readies, RF port,
//             conflict counter
module reg_file_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  reg_file_wb_arbiter_if.slave  bus
);

  localparam logic [1:0] SEL_LW  = 2'b00;
  localparam logic [1:0] SEL_LB  = 2'b01;
  localparam logic [1:0] SEL_LUI = 2'b10;
  localparam logic [1:0] SEL_ALU = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Priority pointer names the requester that wins the next conflict.
  typedef enum logic {
    PTR_L = 1'b0,
    PTR_A = 1'b1
  } ptr_t;

  ptr_t r_ptr;
  ptr_t w_ptr_nxt;

  logic w_a_elig;
  logic w_l_elig;
  logic w_conflict;
  logic w_grant_a;
  logic w_grant_l;

  logic              w_grant_p0;
  logic [ADDR_W-1:0] w_waddr_p0;
  logic [DATA_W-1:0] w_wdata_p0;
  logic [1:0]        w_sel_p0;

  logic              r_we_p1;
  logic [ADDR_W-1:0] r_waddr_p1;
  logic [DATA_W-1:0] r_wdata_p1;
  logic [1:0]        r_sel_p1;
  logic [CNT_W-1:0]  r_conflict_cnt;

  function automatic logic [DATA_W-1:0] fmt_lui(input logic [15:0] imm16);
    return {imm16, {(DATA_W-16){1'b0}}};
  endfunction

  function automatic logic [DATA_W-1:0] fmt_load_byte(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        boff,
    input logic              sgn
  );
    logic [7:0] b;
    b = word[8*boff +: 8];
    return sgn ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_ONE;
  endfunction

  // ---- Stage p0: eligibility, arbitration, pointer next-state ----
  always_comb begin
    w_a_elig   = bus.w_a_valid && !bus.w_flush;
    w_l_elig   = bus.w_l_valid;
    w_conflict = w_a_elig && w_l_elig;
    w_grant_a  = w_a_elig && (!w_l_elig || (r_ptr == PTR_A));
    w_grant_l  = w_l_elig && (!w_a_elig || (r_ptr == PTR_L));
    w_ptr_nxt  = r_ptr;
    // The winner of a conflict hands priority to the loser.
    if (w_conflict) begin
      w_ptr_nxt = (r_ptr == PTR_L) ? PTR_A : PTR_L;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= PTR_L;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign bus.w_a_ready = w_grant_a;
  assign bus.w_l_ready = w_grant_l;

  // ---- Stage p0: write-data formatting for the granted requester ----
  always_comb begin
    w_grant_p0 = 1'b0;
    w_waddr_p0 = '0;
    w_wdata_p0 = '0;
    w_sel_p0   = SEL_LW;
    if (w_grant_a) begin
      w_grant_p0 = 1'b1;
      w_waddr_p0 = bus.w_a_waddr;
      if (bus.w_a_imm_op) begin
        w_wdata_p0 = fmt_lui(bus.w_a_imm16);
        w_sel_p0   = SEL_LUI;
      end else begin
        w_wdata_p0 = bus.w_a_result;
        w_sel_p0   = SEL_ALU;
      end
    end else if (w_grant_l) begin
      w_grant_p0 = 1'b1;
      w_waddr_p0 = bus.w_l_waddr;
      if (bus.w_l_byte_op) begin
        w_wdata_p0 = fmt_load_byte(bus.w_l_rdata, bus.w_l_boff, bus.w_l_signed);
        w_sel_p0   = SEL_LB;
      end else begin
        w_wdata_p0 = bus.w_l_rdata;
        w_sel_p0   = SEL_LW;
      end
    end
  end

  // ---- Stage p1: registered register-file write ----
  // Register 0 is hard-wired, so its write enable is suppressed while the
  // address, data and sel still follow the granted request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we_p1    <= 1'b0;
      r_waddr_p1 <= '0;
      r_wdata_p1 <= '0;
      r_sel_p1   <= SEL_LW;
    end else if (w_grant_p0) begin
      r_we_p1    <= (w_waddr_p0 != '0);
      r_waddr_p1 <= w_waddr_p0;
      r_wdata_p1 <= w_wdata_p0;
      r_sel_p1   <= w_sel_p0;
    end else begin
      r_we_p1    <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict) begin
      r_conflict_cnt <= sat_inc(r_conflict_cnt);
    end
  end

  assign bus.w_rf_we        = r_we_p1;
  assign bus.w_rf_waddr     = r_waddr_p1;
  assign bus.w_rf_wdata     = r_wdata_p1;
  assign bus.w_wdata_sel    = r_sel_p1;
  assign bus.w_conflict_cnt = r_conflict_cnt;

endmodule
